// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage: IF/ID register, operand-use flags, hazard stall, ID/EX register.
// Optional macro DECODE_ILLEGAL_EN flags non-RV32I opcodes on o_ex_illegal instead of decoding them as NOP.
module id_stage #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ce,
  input  logic            i_if_valid,
  input  logic [XLEN-1:0] i_if_inst,
  input  logic [XLEN-1:0] i_if_pc,
  output logic            o_if_ready,
  input  logic            i_flush,
  input  logic            i_hz_data,
  output logic [4:0]      o_addr_rd_a,
  output logic [4:0]      o_addr_rd_b,
  output logic            o_hz_rs1,
  output logic            o_hz_rs2,
  output logic            o_ex_valid,
  output logic [XLEN-1:0] o_ex_pc,
  output logic [6:0]      o_ex_opcode,
  output logic [2:0]      o_ex_funct3,
  output logic            o_ex_funct7b5,
  output logic [XLEN-1:0] o_ex_imm,
  output logic [4:0]      o_ex_wb_reg,
  output logic            o_ex_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic            id_valid;
  logic [XLEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;

  logic            use_rs1, use_rs2, does_wb, legal;
  logic [XLEN-1:0] imm_raw;
  logic [6:0]      d_opcode;
  logic [2:0]      d_funct3;
  logic            d_funct7b5;
  logic [XLEN-1:0] d_imm;
  logic [4:0]      d_wb_reg;
  logic            d_illegal;
  logic            stall;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    does_wb = 1'b0;
    legal   = 1'b1;
    imm_raw = '0;
    case (id_inst[6:0])
      OP_LUI, OP_AUIPC: begin
        does_wb = 1'b1;
        imm_raw = {id_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        does_wb = 1'b1;
        imm_raw = {{12{id_inst[31]}}, id_inst[19:12], id_inst[20], id_inst[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_OPIMM: begin
        use_rs1 = 1'b1;
        does_wb = 1'b1;
        imm_raw = {{20{id_inst[31]}}, id_inst[31:20]};
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm_raw = {{20{id_inst[31]}}, id_inst[7], id_inst[30:25], id_inst[11:8], 1'b0};
      end
      OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm_raw = {{20{id_inst[31]}}, id_inst[31:25], id_inst[11:7]};
      end
      OP_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        does_wb = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: imm_raw = {{20{id_inst[31]}}, id_inst[31:20]};
      default: legal = 1'b0;
    endcase

    d_opcode   = id_inst[6:0];
    d_funct3   = id_inst[14:12];
    d_funct7b5 = id_inst[30];
    d_imm      = imm_raw;
    d_wb_reg   = does_wb ? id_inst[11:7] : 5'd0;
`ifdef DECODE_ILLEGAL_EN
    d_illegal  = ~legal;
`else
    d_illegal  = 1'b0;
    // Unknown opcodes travel down the pipe as a canonical ADDI x0,x0,0.
    if (!legal) begin
      d_opcode   = OP_OPIMM;
      d_funct3   = 3'd0;
      d_funct7b5 = 1'b0;
      d_imm      = '0;
    end
`endif
  end

  assign o_addr_rd_a = id_inst[19:15];
  assign o_addr_rd_b = id_inst[24:20];
  assign o_hz_rs1    = id_valid & use_rs1;
  assign o_hz_rs2    = id_valid & use_rs2;
  assign stall       = id_valid & i_hz_data;
  assign o_if_ready  = ~stall;

  always_ff @(posedge i_clk) begin
    if (i_ce) begin
      if (i_rst) begin
        id_valid      <= 1'b0;
        id_inst       <= 32'h0000_0013;
        id_pc         <= RESET_PC;
        o_ex_valid    <= 1'b0;
        o_ex_pc       <= RESET_PC;
        o_ex_opcode   <= 7'd0;
        o_ex_funct3   <= 3'd0;
        o_ex_funct7b5 <= 1'b0;
        o_ex_imm      <= '0;
        o_ex_wb_reg   <= 5'd0;
        o_ex_illegal  <= 1'b0;
      end else if (i_flush) begin
        id_valid     <= 1'b0;
        o_ex_valid   <= 1'b0;
        o_ex_wb_reg  <= 5'd0;
        o_ex_illegal <= 1'b0;
      end else if (stall) begin
        o_ex_valid   <= 1'b0;
        o_ex_wb_reg  <= 5'd0;
        o_ex_illegal <= 1'b0;
      end else begin
        o_ex_valid    <= id_valid;
        o_ex_pc       <= id_pc;
        o_ex_opcode   <= d_opcode;
        o_ex_funct3   <= d_funct3;
        o_ex_funct7b5 <= d_funct7b5;
        o_ex_imm      <= d_imm;
        o_ex_wb_reg   <= id_valid ? d_wb_reg : 5'd0;
        o_ex_illegal  <= id_valid & d_illegal;
        id_valid      <= i_if_valid;
        id_inst       <= i_if_inst;
        id_pc         <= i_if_pc;
      end
    end
  end

endmodule
